// File: rtl/load_store_unit_pkg.sv
// Shared encodings for the load/store unit: access sizes, FSM states and
// lane-geometry helpers used by the top and the lane aligner.
package load_store_unit_pkg;

    typedef enum logic [1:0] {
        SZ_B = 2'd0,
        SZ_H = 2'd1,
        SZ_W = 2'd2,
        SZ_D = 2'd3
    } size_e;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_ISSUE0 = 3'd1,
        S_WAIT0  = 3'd2,
        S_ISSUE1 = 3'd3,
        S_WAIT1  = 3'd4,
        S_RESP   = 3'd5
    } state_e;

    localparam int BYTE_W = 8;

    // Bits of the byte address that select a lane within one bus word.
    function automatic int off_bits(input int data_w);
        return $clog2(data_w / BYTE_W);
    endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// MEM-stage request, data-RAM bus and WB response signals of the LSU.
// The slave modport is the unit's view; master is the surrounding pipeline/memory.
interface load_store_unit_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32,
    parameter int REG_AW = 5
) ();
    logic                  req_valid;
    logic                  req_ready;
    logic                  req_write;
    logic                  req_sign;
    logic [1:0]            req_size;
    logic [ADDR_W-1:0]     req_addr;
    logic [DATA_W-1:0]     req_wdata;
    logic [REG_AW-1:0]     req_rd;
    logic [ADDR_W-1:0]     req_pc;

    logic                  bus_req;
    logic                  bus_we;
    logic [ADDR_W-1:0]     bus_addr;
    logic [DATA_W/8-1:0]   bus_be;
    logic [DATA_W-1:0]     bus_wdata;
    logic                  bus_gnt;
    logic                  bus_rvalid;
    logic [DATA_W-1:0]     bus_rdata;

    logic                  rsp_valid;
    logic [DATA_W-1:0]     rsp_data;
    logic                  rsp_reg_we;
    logic [REG_AW-1:0]     rsp_rd;
    logic [ADDR_W-1:0]     rsp_pc;
    logic                  rsp_err;

    modport slave (
        input  req_valid, req_write, req_sign, req_size, req_addr, req_wdata, req_rd, req_pc,
        output req_ready,
        output bus_req, bus_we, bus_addr, bus_be, bus_wdata,
        input  bus_gnt, bus_rvalid, bus_rdata,
        output rsp_valid, rsp_data, rsp_reg_we, rsp_rd, rsp_pc, rsp_err
    );

    modport master (
        output req_valid, req_write, req_sign, req_size, req_addr, req_wdata, req_rd, req_pc,
        input  req_ready,
        input  bus_req, bus_we, bus_addr, bus_be, bus_wdata,
        output bus_gnt, bus_rvalid, bus_rdata,
        input  rsp_valid, rsp_data, rsp_reg_we, rsp_rd, rsp_pc, rsp_err
    );

endinterface

// File: rtl/lsu_lane_align.sv
// Combinational lane logic: byte enables and shifted store data over a
// two-word window, plus extraction and sign/zero extension of load data.
module lsu_lane_align
    import load_store_unit_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [off_bits(DATA_W)-1:0] i_off,
    input  size_e                       i_size,
    input  logic                        i_sign,
    input  logic [DATA_W-1:0]           i_wdata,
    input  logic [2*DATA_W-1:0]         i_rdata2,
    output logic [2*DATA_W/8-1:0]       o_be2,
    output logic [2*DATA_W-1:0]         o_wdata2,
    output logic [DATA_W-1:0]           o_rdata
);
    localparam int NB = DATA_W / BYTE_W;

    logic [3:0]          w_nbytes;
    logic [DATA_W-1:0]   w_mask;
    logic [2*DATA_W-1:0] w_sh;
    logic                w_sbit;

    assign w_nbytes = 4'd1 << i_size;

    always_comb begin
        o_be2 = '0;
        for (int b = 0; b < 2*NB; b++)
            o_be2[b] = (b >= int'(i_off)) && (b < int'(i_off) + int'(w_nbytes));
    end

    // Byte mask of the access width, shared by store masking and load truncation.
    always_comb begin
        w_mask = '0;
        for (int b = 0; b < NB; b++)
            w_mask[b*BYTE_W +: BYTE_W] = (b < int'(w_nbytes)) ? 8'hFF : 8'h00;
    end

    assign o_wdata2 = {{DATA_W{1'b0}}, i_wdata & w_mask} << {i_off, 3'b000};

    assign w_sh = i_rdata2 >> {i_off, 3'b000};

    always_comb begin
        w_sbit = 1'b0;
        case (i_size)
            SZ_B:    w_sbit = w_sh[7];
            SZ_H:    w_sbit = w_sh[15];
            SZ_W:    w_sbit = w_sh[31];
            default: w_sbit = w_sh[63];
        endcase
    end

    assign o_rdata = (w_sh[DATA_W-1:0] & w_mask) | ((i_sign && w_sbit) ? ~w_mask : '0);

endmodule

// File: rtl/load_store_unit.sv
// Single-outstanding load/store unit between MEM and the data-RAM bus, with
// optional two-beat handling of accesses that cross a bus word.
module load_store_unit
    import load_store_unit_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 32,
    parameter int REG_AW   = 5,
    parameter bit SPLIT_EN = 1'b1
) (
    input  logic               clk,
    input  logic               rst_n,
    load_store_unit_if.slave   io
);
    localparam int NB    = DATA_W / BYTE_W;
    localparam int OFF_W = off_bits(DATA_W);

    state_e              r_state, w_next;
    logic                r_write, r_sign, r_err;
    size_e               r_size;
    logic [ADDR_W-1:0]   r_addr, r_pc;
    logic [DATA_W-1:0]   r_wdata;
    logic [REG_AW-1:0]   r_rd;
    logic [2*DATA_W-1:0] r_rdata2;

    logic                w_in_cross, w_in_err, w_split;
    logic [ADDR_W-1:0]   w_addr_al;
    logic [2*NB-1:0]     w_be2;
    logic [2*DATA_W-1:0] w_wdata2;
    logic [DATA_W-1:0]   w_rdata;

    // Error is decided on the incoming request so a bad access goes straight to RESP.
    assign w_in_cross = (int'(io.req_addr[OFF_W-1:0]) + (1 << io.req_size)) > NB;
    assign w_in_err   = (DATA_W == 32 && io.req_size == SZ_D) || (!SPLIT_EN && w_in_cross);

    assign w_addr_al = {r_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
    assign w_split   = |w_be2[2*NB-1:NB];

    lsu_lane_align #(.DATA_W(DATA_W)) u_align (
        .i_off    (r_addr[OFF_W-1:0]),
        .i_size   (r_size),
        .i_sign   (r_sign),
        .i_wdata  (r_wdata),
        .i_rdata2 (r_rdata2),
        .o_be2    (w_be2),
        .o_wdata2 (w_wdata2),
        .o_rdata  (w_rdata)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_write  <= 1'b0;
            r_sign   <= 1'b0;
            r_err    <= 1'b0;
            r_size   <= SZ_B;
            r_addr   <= '0;
            r_pc     <= '0;
            r_wdata  <= '0;
            r_rd     <= '0;
            r_rdata2 <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == S_IDLE && io.req_valid) begin
                r_write <= io.req_write;
                r_sign  <= io.req_sign;
                r_err   <= w_in_err;
                r_size  <= size_e'(io.req_size);
                r_addr  <= io.req_addr;
                r_pc    <= io.req_pc;
                r_wdata <= io.req_wdata;
                r_rd    <= io.req_rd;
            end
            if (r_state == S_WAIT0 && io.bus_rvalid)
                r_rdata2[DATA_W-1:0] <= io.bus_rdata;
            if (r_state == S_WAIT1 && io.bus_rvalid)
                r_rdata2[2*DATA_W-1:DATA_W] <= io.bus_rdata;
        end
    end

    always_comb begin
        w_next        = r_state;
        io.req_ready  = 1'b0;
        io.bus_req    = 1'b0;
        io.bus_we     = 1'b0;
        io.bus_addr   = '0;
        io.bus_be     = '0;
        io.bus_wdata  = '0;
        io.rsp_valid  = 1'b0;
        io.rsp_data   = '0;
        io.rsp_reg_we = 1'b0;
        io.rsp_rd     = '0;
        io.rsp_pc     = '0;
        io.rsp_err    = 1'b0;
        case (r_state)
            S_IDLE: begin
                io.req_ready = 1'b1;
                if (io.req_valid)
                    w_next = w_in_err ? S_RESP : S_ISSUE0;
            end
            S_ISSUE0: begin
                io.bus_req   = 1'b1;
                io.bus_we    = r_write;
                io.bus_addr  = w_addr_al;
                io.bus_be    = w_be2[NB-1:0];
                io.bus_wdata = w_wdata2[DATA_W-1:0];
                if (io.bus_gnt) begin
                    if (!r_write)     w_next = S_WAIT0;
                    else if (w_split) w_next = S_ISSUE1;
                    else              w_next = S_RESP;
                end
            end
            S_WAIT0: begin
                if (io.bus_rvalid)
                    w_next = w_split ? S_ISSUE1 : S_RESP;
            end
            S_ISSUE1: begin
                io.bus_req   = 1'b1;
                io.bus_we    = r_write;
                io.bus_addr  = w_addr_al + ADDR_W'(NB);
                io.bus_be    = w_be2[2*NB-1:NB];
                io.bus_wdata = w_wdata2[2*DATA_W-1:DATA_W];
                if (io.bus_gnt)
                    w_next = r_write ? S_RESP : S_WAIT1;
            end
            S_WAIT1: begin
                if (io.bus_rvalid)
                    w_next = S_RESP;
            end
            S_RESP: begin
                io.rsp_valid  = 1'b1;
                io.rsp_err    = r_err;
                io.rsp_rd     = r_rd;
                io.rsp_pc     = r_pc;
                io.rsp_reg_we = !r_write && !r_err;
                io.rsp_data   = (r_write || r_err) ? '0 : w_rdata;
                w_next        = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

endmodule
